// File: rtl/acc_bus_master.sv
// Command-FIFO-fed master for an accumulate / read-and-clear peripheral on a shared tristate bus.
// Define ACC_MASTER_SHADOW_EN to add a write-sum shadow that flags read mismatches on RspErr.
module acc_bus_master #(
  parameter int DEPTH    = 4,
  parameter int TURN_CYC = 1
) (
  input  logic       Clk,
  input  logic       RSt,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic       CmdRnW,
  input  logic [7:0] CmdData,
  output logic       RspValid,
  output logic [7:0] RspData,
  output logic       RspErr,
  output logic       Busy,
  output logic       Sel,
  output logic       RnW,
  inout  wire  [7:0] Dio
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [1:0]    turn_q, turn_d;
  logic          sel_q, sel_d;
  logic          rnw_q, rnw_d;
  logic          oe_q, oe_d;
  logic [7:0]    dout_q, dout_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          push, pop, dispatch;
  logic [8:0]    head;

  assign CmdReady = !RSt && (count_q != CW'(DEPTH));
  assign push     = CmdValid && CmdReady;
  assign head     = mem[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    sel_d       = sel_q;
    rnw_d       = rnw_q;
    oe_d        = oe_q;
    dout_d      = dout_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    dispatch    = 1'b0;
    pop         = 1'b0;

    case (state_q)
      IDLE, WRITE: dispatch = 1'b1;
      READ: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = Dio;
        if (TURN_CYC > 0) begin
          state_d = TURN;
          turn_d  = 2'(TURN_CYC - 1);
          sel_d   = 1'b0;
          rnw_d   = 1'b1;
          oe_d    = 1'b0;
        end else begin
          dispatch = 1'b1;
        end
      end
      TURN: begin
        if (turn_q == 2'd0) dispatch = 1'b1;
        else turn_d = turn_q - 2'd1;
      end
      default: dispatch = 1'b1;
    endcase

    // Bus enable and direction are decided together so the master never drives while RnW=1.
    if (dispatch) begin
      if (count_q != '0) begin
        pop     = 1'b1;
        sel_d   = 1'b1;
        rnw_d   = head[8];
        oe_d    = !head[8];
        dout_d  = head[7:0];
        state_d = head[8] ? READ : WRITE;
      end else begin
        state_d = IDLE;
        sel_d   = 1'b0;
        rnw_d   = 1'b1;
        oe_d    = 1'b0;
      end
    end

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_q] <= {CmdRnW, CmdData};
    if (RSt) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      turn_q      <= 2'd0;
      sel_q       <= 1'b0;
      rnw_q       <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      turn_q      <= turn_d;
      sel_q       <= sel_d;
      rnw_q       <= rnw_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef ACC_MASTER_SHADOW_EN
  logic [7:0] shadow_q, shadow_d;
  logic       rsp_err_q, rsp_err_d;

  // Shadow mirrors what this master wrote since the last read-and-clear.
  always_comb begin
    shadow_d  = shadow_q;
    rsp_err_d = rsp_err_q;
    if (state_q == WRITE) begin
      shadow_d = shadow_q + dout_q;
    end else if (state_q == READ) begin
      rsp_err_d = (Dio != shadow_q);
      shadow_d  = 8'h00;
    end
  end

  always_ff @(posedge Clk) begin
    if (RSt) begin
      shadow_q  <= 8'h00;
      rsp_err_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign RspErr = rsp_err_q;
`else
  assign RspErr = 1'b0;
`endif

  assign Dio      = oe_q ? dout_q : 8'hzz;
  assign Sel      = sel_q;
  assign RnW      = rnw_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign Busy     = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_acc_bus_master.sv
// Bench for acc_bus_master: directed scenarios plus random traffic against a command-level model.
module tb_acc_bus_master;

  localparam int DEPTH = 4;
  localparam int TURN  = 2;
`ifdef ACC_MASTER_SHADOW_EN
  localparam logic SHADOW = 1'b1;
`else
  localparam logic SHADOW = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic       b;
    logic [7:0] data;
  } log_t;

  typedef struct {
    logic       b;
    logic [7:0] data;
  } exp_t;

  logic       Clk, RSt, CmdValid, CmdReady, CmdRnW;
  logic [7:0] CmdData;
  logic       RspValid, RspErr, Busy, Sel, RnW;
  logic [7:0] RspData;
  wire  [7:0] Dio;

  logic [7:0] periph_acc;
  logic       ext_we, ext_clr;
  logic [7:0] ext_data;

  int   cyc = 0;
  bit   log_en = 1'b0;
  log_t bus_log[$];
  log_t rsp_log[$];
  exp_t exp_bus[$];
  exp_t exp_rsp[$];
  int   bus_idx = 0, rsp_idx = 0;
  int   n_pushed = 0;
  int   n_assert = 0, n_fail = 0;
  logic [7:0] m_acc = 8'h00, m_sh = 8'h00;
  bit   saw_full = 1'b0;

  acc_bus_master #(.DEPTH(DEPTH), .TURN_CYC(TURN)) dut (
    .Clk(Clk), .RSt(RSt), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdRnW(CmdRnW), .CmdData(CmdData), .RspValid(RspValid), .RspData(RspData),
    .RspErr(RspErr), .Busy(Busy), .Sel(Sel), .RnW(RnW), .Dio(Dio)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Peripheral: accumulates bus writes, returns and clears on bus reads.
  assign Dio = (Sel && RnW) ? periph_acc : 8'hzz;
  always @(posedge Clk) begin
    if (ext_clr)             periph_acc <= 8'h00;
    else if (Sel && RnW)     periph_acc <= 8'h00;
    else if (Sel && !RnW)    periph_acc <= periph_acc + Dio;
    else if (ext_we)         periph_acc <= periph_acc + ext_data;
  end

  always @(negedge Clk) begin
    if (log_en) begin
      if (Sel === 1'b1) bus_log.push_back('{cyc, RnW, Dio});
      if (RspValid === 1'b1) rsp_log.push_back('{cyc, RspErr, RspData});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_logs();
    while (bus_idx < bus_log.size()) begin
      if (bus_idx < exp_bus.size()) begin
        chk("bus_rnw", bus_log[bus_idx].b, exp_bus[bus_idx].b);
        chk("bus_dio", bus_log[bus_idx].data, exp_bus[bus_idx].data);
      end else begin
        chk("bus_extra", bus_log.size(), exp_bus.size());
      end
      bus_idx++;
    end
    while (rsp_idx < rsp_log.size()) begin
      if (rsp_idx < exp_rsp.size()) begin
        chk("rsp_data", rsp_log[rsp_idx].data, exp_rsp[rsp_idx].data);
        chk("rsp_err", rsp_log[rsp_idx].b, exp_rsp[rsp_idx].b);
      end else begin
        chk("rsp_extra", rsp_log.size(), exp_rsp.size());
      end
      rsp_idx++;
    end
  endtask

  // Called at a negedge; returns at a later negedge with CmdValid dropped.
  task automatic push_cmd(input logic rnw, input logic [7:0] d, output int ecyc);
    int guard;
    CmdValid = 1'b1;
    CmdRnW   = rnw;
    CmdData  = d;
    guard    = 0;
    #1;
    chk("cmd_ready", CmdReady, (n_pushed - bus_log.size()) != DEPTH);
    while (!CmdReady && guard < 100) begin
      saw_full = 1'b1;
      @(negedge Clk);
      #1;
      guard++;
      chk("cmd_ready", CmdReady, (n_pushed - bus_log.size()) != DEPTH);
    end
    chk("push_wait", guard < 100, 1'b1);
    @(posedge Clk);
    #1;
    ecyc = cyc;
    n_pushed++;
    if (!rnw) begin
      m_acc = m_acc + d;
      m_sh  = m_sh + d;
      exp_bus.push_back('{1'b0, d});
    end else begin
      exp_bus.push_back('{1'b1, m_acc});
      exp_rsp.push_back('{SHADOW && (m_acc != m_sh), m_acc});
      m_acc = 8'h00;
      m_sh  = 8'h00;
    end
    @(negedge Clk);
    CmdValid = 1'b0;
  endtask

  task automatic ext_write(input logic [7:0] d);
    ext_data = d;
    ext_we   = 1'b1;
    @(negedge Clk);
    ext_we   = 1'b0;
    m_acc    = m_acc + d;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    @(negedge Clk);
    #1;
    while ((Busy || bus_log.size() != exp_bus.size() || rsp_log.size() != exp_rsp.size())
           && guard < 300) begin
      @(negedge Clk);
      #1;
      guard++;
    end
    chk("drain_done", guard < 300, 1'b1);
    repeat (2) @(negedge Clk);
    #1;
    check_logs();
    chk("drain_busy", Busy, 1'b0);
  endtask

  initial begin
    int e0, e1, e2, b0, r0;
    RSt = 1'b1; CmdValid = 1'b0; CmdRnW = 1'b0; CmdData = 8'h00;
    ext_we = 1'b0; ext_clr = 1'b1; ext_data = 8'h00;
    repeat (3) @(negedge Clk);
    chk("rst_sel", Sel, 1'b0);
    chk("rst_rnw", RnW, 1'b1);
    chk("rst_rspvalid", RspValid, 1'b0);
    chk("rst_rspdata", RspData, 8'h00);
    chk("rst_rsperr", RspErr, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_cmdready", CmdReady, 1'b0);
    RSt = 1'b0; ext_clr = 1'b0; log_en = 1'b1;
    #1;
    chk("rst_cmdready_after", CmdReady, 1'b1);
    @(negedge Clk);

    // W 05, W 0A, R: three back-to-back bus cycles, sum returned.
    b0 = bus_log.size(); r0 = rsp_log.size();
    push_cmd(1'b0, 8'h05, e0);
    push_cmd(1'b0, 8'h0A, e1);
    push_cmd(1'b1, 8'h00, e2);
    drain();
    chk("b2b_sel_cyc0", bus_log[b0].cyc, e0 + 1);
    chk("b2b_sel_cyc1", bus_log[b0+1].cyc, e0 + 2);
    chk("b2b_sel_cyc2", bus_log[b0+2].cyc, e0 + 3);
    chk("b2b_dio0", bus_log[b0].data, 8'h05);
    chk("b2b_dio1", bus_log[b0+1].data, 8'h0A);
    chk("b2b_rsp_cyc", rsp_log[r0].cyc, e0 + 4);
    chk("b2b_rsp_data", rsp_log[r0].data, 8'h0F);
    chk("b2b_rsp_err", rsp_log[r0].b, 1'b0);

    // Wrap mod 256, then an immediate second read returns the cleared value.
    b0 = bus_log.size(); r0 = rsp_log.size();
    push_cmd(1'b0, 8'hF0, e0);
    push_cmd(1'b0, 8'h20, e0);
    push_cmd(1'b1, 8'h00, e0);
    push_cmd(1'b1, 8'h00, e0);
    drain();
    chk("wrap_data", rsp_log[r0].data, 8'h10);
    chk("clear_data", rsp_log[r0+1].data, 8'h00);
    chk("rr_turn_gap", bus_log[b0+3].cyc - bus_log[b0+2].cyc, TURN + 1);

    // Read followed by write: exactly TURN idle cycles in between.
    b0 = bus_log.size();
    push_cmd(1'b1, 8'h00, e0);
    push_cmd(1'b0, 8'h33, e0);
    drain();
    chk("rw_turn_gap", bus_log[b0+1].cyc - bus_log[b0].cyc, TURN + 1);
    chk("rw_write_dir", bus_log[b0+1].b, 1'b0);
    chk("rw_write_dio", bus_log[b0+1].data, 8'h33);

    // Reads stall the FSM so the FIFO fills and CmdReady drops.
    saw_full = 1'b0;
    push_cmd(1'b1, 8'h00, e0);
    push_cmd(1'b1, 8'h00, e0);
    push_cmd(1'b1, 8'h00, e0);
    push_cmd(1'b0, 8'h11, e0);
    push_cmd(1'b0, 8'h22, e0);
    push_cmd(1'b1, 8'h00, e0);
    push_cmd(1'b0, 8'h44, e0);
    push_cmd(1'b0, 8'h55, e0);
    drain();
    chk("fifo_full_seen", saw_full, 1'b1);

    // Reset during a read bus cycle aborts it with no response.
    r0 = rsp_log.size();
    push_cmd(1'b1, 8'h00, e0);
    @(negedge Clk);
    #1;
    chk("abort_sel_before", Sel, 1'b1);
    chk("abort_rnw_before", RnW, 1'b1);
    RSt = 1'b1;
    @(negedge Clk);
    chk("abort_sel_after", Sel, 1'b0);
    chk("abort_rspvalid", RspValid, 1'b0);
    chk("abort_cmdready_rst", CmdReady, 1'b0);
    chk("abort_busy", Busy, 1'b0);
    RSt = 1'b0;
    #1;
    chk("abort_cmdready_rel", CmdReady, 1'b1);
    void'(exp_rsp.pop_back());
    n_pushed = bus_log.size();
    repeat (4) @(negedge Clk);
    chk("abort_no_rsp", rsp_log.size(), r0);
    check_logs();

    // Peripheral preloaded from outside: shadow sees only this master's writes.
    r0 = rsp_log.size();
    ext_write(8'h01);
    push_cmd(1'b0, 8'h02, e0);
    push_cmd(1'b1, 8'h00, e0);
    drain();
    chk("preload_data", rsp_log[r0].data, 8'h03);
    chk("preload_err", rsp_log[r0].b, SHADOW);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      int sel_r;
      int e;
      sel_r = $urandom_range(0, 9);
      if (sel_r <= 3) begin
        push_cmd(1'b0, 8'($urandom), e);
      end else if (sel_r <= 6) begin
        push_cmd(1'b1, 8'h00, e);
      end else if (sel_r == 7) begin
        if (!Busy) ext_write(8'($urandom));
        else @(negedge Clk);
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge Clk);
      end
      check_logs();
    end
    drain();
    chk("final_bus_count", bus_log.size(), exp_bus.size());
    chk("final_rsp_count", rsp_log.size(), exp_rsp.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
